// File: rtl/scan_chain_autocheck.sv
// Scan-chain self-test engine: drives a pattern into every chain head, waits out the
// chain length, compares each tail against the delayed pattern and reports results.
module scan_chain_autocheck #(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned CHECK_LEN  = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                        op_clk,
  input  logic                        greset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [1:0]                  mode,
  input  logic [NUM_CHAINS-1:0]       sc_tail,
  output logic [NUM_CHAINS-1:0]       sc_head,
  output logic                        test_en,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [NUM_CHAINS-1:0]       fail_mask,
  output logic [NUM_CHAINS*ERR_W-1:0] err_count
);

  localparam int unsigned IdxW    = $clog2(CHAIN_LEN + CHECK_LEN + 1);
  // Index of the settle cycle that follows the last compare; the chain is still clocked
  // so the final tail sample lands before DONE computes the verdict.
  localparam int unsigned LastIdx = CHAIN_LEN + CHECK_LEN;

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [1:0]              mode_q, mode_d;
  logic [NUM_CHAINS-1:0]   head_q, head_d;
  logic                    test_en_q, test_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [NUM_CHAINS-1:0]   fail_q, fail_d;
  logic [ERR_W-1:0]        err_q [NUM_CHAINS];
  logic [ERR_W-1:0]        err_d [NUM_CHAINS];
  logic                    exp_bit;

  // Pattern bit for stream index i; reserved mode 3 falls back to pulse.
  function automatic logic pat(input logic [1:0] m, input logic [IdxW-1:0] i);
    logic r;
    case (m)
      2'd1:    r = ~i[0];
      2'd2:    r = (i < IdxW'(CHECK_LEN));
      default: r = (i == '0);
    endcase
    return r;
  endfunction

  // Expected tail bit for the current CHECK index.
  always_comb begin
    exp_bit = pat(mode_q, idx_q - IdxW'(CHAIN_LEN));
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    head_d    = head_q;
    test_en_d = test_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
      err_d[c] = err_q[c];
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StRun;
          mode_d    = mode;
          idx_d     = '0;
          head_d    = {NUM_CHAINS{pat(mode, '0)}};
          test_en_d = 1'b1;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          fail_d    = '0;
          for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
            err_d[c] = '0;
          end
        end
      end
      StRun: begin
        idx_d  = idx_q + 1'b1;
        head_d = {NUM_CHAINS{pat(mode_q, idx_q + 1'b1)}};
        if (idx_q == IdxW'(CHAIN_LEN - 1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (idx_q == IdxW'(LastIdx)) begin
          state_d   = StDone;
          head_d    = '0;
          test_en_d = 1'b0;
          done_d    = 1'b1;
          pass_d    = ~|fail_q;
        end else begin
          idx_d  = idx_q + 1'b1;
          head_d = {NUM_CHAINS{pat(mode_q, idx_q + 1'b1)}};
          for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
            if (sc_tail[c] != exp_bit) begin
              fail_d[c] = 1'b1;
              if (err_q[c] != {ERR_W{1'b1}}) begin
                err_d[c] = err_q[c] + ERR_W'(1);
              end
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition of a running test; counters keep partial values.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      head_d    = '0;
      test_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge op_clk or posedge greset) begin
    if (greset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mode_q    <= 2'd0;
      head_q    <= '0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
        err_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      head_q    <= head_d;
      test_en_q <= test_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
        err_q[c] <= err_d[c];
      end
    end
  end

  // Flatten per-chain counters onto the output bus.
  always_comb begin
    err_count = '0;
    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
      err_count[c*ERR_W +: ERR_W] = err_q[c];
    end
  end

  assign sc_head   = head_q;
  assign test_en   = test_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_scan_chain_autocheck.sv
// Directed bench: three modelled 8-flop chains on the main instance (with stuck-at and
// short-chain fault injection) plus a 2-bit-counter instance with its tail tied low.
module tb_scan_chain_autocheck;

  localparam int CL = 8;
  localparam int CK = 4;

  logic        clk = 1'b0;
  logic        greset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;

  logic [2:0]  sc_tail, sc_head;
  logic        test_en, busy, done, pass;
  logic [2:0]  fail_mask;
  logic [23:0] err_count;

  logic        s_head, s_test_en, s_busy, s_done, s_pass, s_fail;
  logic [1:0]  s_err;

  logic [CL-1:0] ch [3];
  logic          stuck_en = 1'b0;
  logic          short_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  logic [3:0] tails;

  always #5 clk = ~clk;

  scan_chain_autocheck #(
    .NUM_CHAINS(3), .CHAIN_LEN(CL), .CHECK_LEN(CK), .ERR_W(8)
  ) u_dut (
    .op_clk(clk), .greset(greset), .start(start), .abort(abort), .mode(mode),
    .sc_tail(sc_tail), .sc_head(sc_head), .test_en(test_en), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .err_count(err_count)
  );

  scan_chain_autocheck #(
    .NUM_CHAINS(1), .CHAIN_LEN(CL), .CHECK_LEN(CK), .ERR_W(2)
  ) u_sat (
    .op_clk(clk), .greset(greset), .start(start), .abort(abort), .mode(mode),
    .sc_tail(1'b0), .sc_head(s_head), .test_en(s_test_en), .busy(s_busy), .done(s_done),
    .pass(s_pass), .fail_mask(s_fail), .err_count(s_err)
  );

  // Chain models: chain 0 can have flop 3 stuck at 1, chain 1 can be one flop short.
  initial begin
    for (int c = 0; c < 3; c++) ch[c] = '0;
  end
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) ch[c] <= {ch[c][CL-2:0], sc_head[c]};
    if (stuck_en) ch[0][3] <= 1'b1;
  end
  assign sc_tail[0] = ch[0][CL-1];
  assign sc_tail[1] = short_en ? ch[1][CL-2] : ch[1][CL-1];
  assign sc_tail[2] = ch[2][CL-1];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; records chain-0 tail during the CHECK window.
  task automatic wait_done(output int l, output logic [3:0] tl);
    l  = -1;
    tl = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i >= CL && i < CL + CK) tl[i-CL] = sc_tail[0];
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({sc_head, test_en, busy, done, pass, fail_mask} !== 10'd0 || err_count !== 24'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got head=%b en=%b busy=%b done=%b pass=%b fm=%b err=%h, want all 0",
               sc_head, test_en, busy, done, pass, fail_mask, err_count);
    end
    n_checks++;
    if ({s_head, s_test_en, s_busy, s_done, s_pass, s_fail, s_err} !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_sat_outputs: got %b, want 0",
               {s_head, s_test_en, s_busy, s_done, s_pass, s_fail, s_err});
    end
    @(negedge clk);
    greset = 1'b0;
    idle(3);
  endtask

  task automatic test_pulse;
    launch(2'd0);
    n_checks++;
    if ({busy, test_en, sc_head} !== 5'b11111) begin
      n_errors++;
      $display("FAIL pulse_accept: got busy=%b en=%b head=%b, want 1 1 111", busy, test_en, sc_head);
    end
    wait_done(lat, tails);
    n_checks++;
    if (lat !== 13) begin
      n_errors++;
      $display("FAIL pulse_latency: got %0d, want 13", lat);
    end
    n_checks++;
    if ({pass, fail_mask, busy, test_en, sc_head} !== 9'b1_000_1_0_000 || err_count !== 24'd0) begin
      n_errors++;
      $display("FAIL pulse_result: got pass=%b fm=%b busy=%b en=%b head=%b err=%h, want 1 000 1 0 000 0",
               pass, fail_mask, busy, test_en, sc_head, err_count);
    end
    n_checks++;
    if (tails !== 4'b0001) begin
      n_errors++;
      $display("FAIL pulse_tail: got %b (j3..j0), want 0001", tails);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy, pass} !== 3'b001) begin
      n_errors++;
      $display("FAIL pulse_after_done: got done=%b busy=%b pass=%b, want 0 0 1", done, busy, pass);
    end
    idle(12);
  endtask

  task automatic test_stuck;
    stuck_en = 1'b1;
    idle(10);
    launch(2'd0);
    wait_done(lat, tails);
    stuck_en = 1'b0;
    n_checks++;
    if (tails !== 4'b1111) begin
      n_errors++;
      $display("FAIL stuck_tail: got %b, want 1111", tails);
    end
    n_checks++;
    if (err_count !== 24'h000003 || fail_mask !== 3'b001 || pass !== 1'b0) begin
      n_errors++;
      $display("FAIL stuck_result: got err=%h fm=%b pass=%b, want 000003 001 0",
               err_count, fail_mask, pass);
    end
    idle(14);
  endtask

  task automatic test_short;
    short_en = 1'b1;
    launch(2'd1);
    wait_done(lat, tails);
    n_checks++;
    if (err_count !== 24'h000400 || fail_mask !== 3'b010 || pass !== 1'b0) begin
      n_errors++;
      $display("FAIL short_result: got err=%h fm=%b pass=%b, want 000400 010 0",
               err_count, fail_mask, pass);
    end
    n_checks++;
    if (tails !== 4'b0101) begin
      n_errors++;
      $display("FAIL alt_tail: got %b (j3..j0), want 0101", tails);
    end
    short_en = 1'b0;
    idle(14);
  endtask

  task automatic test_flood_sat;
    launch(2'd2);
    wait_done(lat, tails);
    n_checks++;
    if (pass !== 1'b1 || err_count !== 24'd0 || tails !== 4'b1111) begin
      n_errors++;
      $display("FAIL flood_clean: got pass=%b err=%h tail=%b, want 1 0 1111", pass, err_count, tails);
    end
    n_checks++;
    if (s_err !== 2'd3 || s_pass !== 1'b0 || s_fail !== 1'b1 || s_done !== 1'b1) begin
      n_errors++;
      $display("FAIL flood_saturate: got err=%0d pass=%b fm=%b done=%b, want 3 0 1 1",
               s_err, s_pass, s_fail, s_done);
    end
    idle(14);
  endtask

  task automatic test_mode3;
    launch(2'd3);
    wait_done(lat, tails);
    n_checks++;
    if (lat !== 13 || pass !== 1'b1 || tails !== 4'b0001) begin
      n_errors++;
      $display("FAIL mode3_as_pulse: got lat=%0d pass=%b tail=%b, want 13 1 0001", lat, pass, tails);
    end
    idle(14);
  endtask

  task automatic test_abort;
    int seen;
    launch(2'd0);
    idle(3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if ({busy, test_en, sc_head, done, pass} !== 7'd0) begin
      n_errors++;
      $display("FAIL abort_outputs: got busy=%b en=%b head=%b done=%b pass=%b, want all 0",
               busy, test_en, sc_head, done, pass);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
    end
    launch(2'd0);
    wait_done(lat, tails);
    n_checks++;
    if (lat !== 13 || pass !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_rerun: got lat=%0d pass=%b, want 13 1", lat, pass);
    end
    idle(14);
  endtask

  task automatic test_start_abort_idle;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || test_en !== 1'b0) begin
      n_errors++;
      $display("FAIL start_abort_idle: got busy=%b en=%b, want 0 0", busy, test_en);
    end
    idle(3);
  endtask

  task automatic test_start_held;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk);
    #1;
    mode = 2'd1;
    wait_done(lat, tails);
    start = 1'b0;
    n_checks++;
    if (lat !== 13 || pass !== 1'b1 || tails !== 4'b0001) begin
      n_errors++;
      $display("FAIL start_held: got lat=%0d pass=%b tail=%b, want 13 1 0001", lat, pass, tails);
    end
    idle(14);
  endtask

  task automatic test_back_to_back;
    launch(2'd0);
    wait_done(lat, tails);
    start = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_start_in_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    wait_done(lat, tails);
    n_checks++;
    if (lat !== 13 || pass !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second: got lat=%0d pass=%b, want 13 1", lat, pass);
    end
    idle(14);
  endtask

  task automatic test_greset_check;
    short_en = 1'b1;
    launch(2'd1);
    idle(10);
    n_checks++;
    if (test_en !== 1'b1 || err_count !== 24'h000200) begin
      n_errors++;
      $display("FAIL greset_precheck: got en=%b err=%h, want 1 000200", test_en, err_count);
    end
    #2;
    greset = 1'b1;
    #1;
    n_checks++;
    if ({sc_head, test_en, busy, done, pass, fail_mask} !== 10'd0 || err_count !== 24'd0) begin
      n_errors++;
      $display("FAIL greset_mid_check: got head=%b en=%b busy=%b done=%b pass=%b fm=%b err=%h, want all 0",
               sc_head, test_en, busy, done, pass, fail_mask, err_count);
    end
    @(negedge clk);
    greset   = 1'b0;
    short_en = 1'b0;
    idle(14);
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_stuck();
    test_short();
    test_flood_sat();
    test_mode3();
    test_abort();
    test_start_abort_idle();
    test_start_held();
    test_back_to_back();
    test_greset_check();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
